// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the clock-enable controller.
//   state_t : controller FSM states
//   MIN_DIV : smallest divide ratio that produces a valid period
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_en_ctrl_period_counter.sv
// Period counter for the clock-enable controller.
// Counts 0..cur_div-1. The caller requests the wrap via clear, so the restart
// and the ratio change at a boundary happen in the same edge.
// boundary and phase are flops that describe the current cycle. They are
// computed from the counter value and ratio that will hold in the next cycle.
// Ports:
//   clk_in, reset_n : clock, asynchronous active-low reset
//   cur_div         : ratio in force during the coming cycle
//   clear           : coming cycle starts a fresh period (count 0)
//   enable          : counter is live in the coming cycle (else outputs low)
//   boundary        : current cycle is the last of its period
//   phase           : current cycle is in the upper floor(cur_div/2) cycles
module period_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] cur_div,
  input  logic             clear,
  input  logic             enable,
  output logic             boundary,
  output logic             phase
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             boundary_q, boundary_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    boundary_d = enable && (cnt_d == cur_div - DIV_W'(1));
    phase_d    = enable && (cnt_d >= cur_div - (cur_div >> 1));
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      boundary_q <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      boundary_q <= boundary_d;
      phase_q    <= phase_d;
    end
  end

  assign boundary = boundary_q;
  assign phase    = phase_q;

endmodule

// File: rtl/clk_en_ctrl.sv
// Programmable clock-enable controller. It emits a one-cycle tick every cur_div
// cycles and a phase square wave. Start and stop are graceful, and ratio
// changes take effect only on a period boundary.
// Ports:
//   clk_in, reset_n    : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready: ratio offer handshake, cfg_div is the offered ratio
//   cfg_err            : one-cycle pulse when an accepted ratio was < MIN_DIV
//   start, stop        : begin / end (at the end of the period) generation
//   tick, phase        : enable pulse and square wave
//   running            : high in RUN or STOPPING
//   cur_div            : ratio currently in force
module clk_en_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             phase,
  output logic             running,
  output logic [DIV_W-1:0] cur_div
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_err_q, cfg_err_d;
  logic             running_q, running_d;

  logic boundary;
  logic cnt_clear, cnt_enable;
  logic accept, div_ok;

  assign accept = cfg_valid && cfg_ready_q;
  assign div_ok = (cfg_div >= DIV_W'(MIN_DIV));

  always_comb begin
    state_d      = state_q;
    cur_div_d    = cur_div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;

    case (state_q)
      IDLE:     if (start && !stop) state_d = RUN;
      // A stop seen on the boundary cycle makes this tick the last one.
      RUN:      if (stop) state_d = boundary ? IDLE : STOPPING;
      STOPPING: begin
        if (start)         state_d = RUN;
        else if (boundary) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase

    if (state_q == IDLE) begin
      // A ratio captured on the final boundary lands here; apply it now.
      if (pend_valid_q) begin
        cur_div_d    = pend_div_q;
        pend_valid_d = 1'b0;
      end else if (accept && div_ok) begin
        cur_div_d = cfg_div;
      end
    end else begin
      if (boundary && pend_valid_q) begin
        cur_div_d    = pend_div_q;
        pend_valid_d = 1'b0;
      end
      // An offer on the boundary cycle waits for the following boundary.
      if (accept && div_ok) begin
        pend_div_d   = cfg_div;
        pend_valid_d = 1'b1;
      end
    end

    cfg_err_d   = accept && !div_ok;
    cfg_ready_d = !pend_valid_d;
    running_d   = (state_d != IDLE);

    // A new period begins on start, after every boundary, and the counter
    // is held at zero whenever the controller is idle.
    cnt_enable = (state_d != IDLE);
    cnt_clear  = (state_q == IDLE) || boundary || (state_d == IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_div_q    <= DIV_W'(DEFAULT_DIV);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      cfg_ready_q  <= 1'b1;
      cfg_err_q    <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      running_q    <= running_d;
    end
  end

  period_counter #(
    .DIV_W (DIV_W)
  ) u_period_counter (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .cur_div  (cur_div_d),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .boundary (boundary),
    .phase    (phase)
  );

  assign tick      = boundary;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign running   = running_q;
  assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_en_ctrl.sv
module tb_clk_en_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic        cfg_err;
  logic        start;
  logic        stop;
  logic        tick;
  logic        phase;
  logic        running;
  logic [15:0] cur_div;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  clk_en_ctrl dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .phase     (phase),
    .running   (running),
    .cur_div   (cur_div)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge: outputs then show this cycle.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_tick"},    32'(tick),      0);
    check_eq({tag, "_phase"},   32'(phase),     0);
    check_eq({tag, "_running"}, 32'(running),   0);
    check_eq({tag, "_ready"},   32'(cfg_ready), 1);
    check_eq({tag, "_err"},     32'(cfg_err),   0);
    check_eq({tag, "_curdiv"},  32'(cur_div),   4);
  endtask

  // Starting on a count-0 cycle, check ncyc cycles of free running at div.
  task automatic run_check(input string tag, input int div, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      int c;
      c = k % div;
      check_eq($sformatf("%s_tick%0d", tag, k),  32'(tick),    32'(c == div - 1));
      check_eq($sformatf("%s_phase%0d", tag, k), 32'(phase),   32'(c >= div - div / 2));
      check_eq($sformatf("%s_run%0d", tag, k),   32'(running), 1);
      step();
    end
    $display("period check %s div=%0d cycles=%0d done", tag, div, ncyc);
  endtask

  initial begin
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    start     = 1'b0;
    stop      = 1'b0;

    // Reset values
    step();
    step();
    check_reset_vals("rst");
    #2 reset_n = 1'b1;
    step();
    check_reset_vals("post_rst");

    // Start at DIV=4: ticks at T+4, T+8, T+12, phase 0,0,1,1
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_cnt0_run", 32'(running), 1);
    run_check("div4", 4, 12);

    // Mid-period write of 6: current period keeps 4, the next one uses 6
    cfg_valid = 1'b1;
    cfg_div   = 16'd6;
    step();
    cfg_valid = 1'b0;
    check_eq("pend_ready_c1", 32'(cfg_ready), 0);
    check_eq("pend_div_c1",   32'(cur_div),   4);
    check_eq("pend_tick_c1",  32'(tick),      0);
    step();
    check_eq("pend_ready_c2", 32'(cfg_ready), 0);
    check_eq("pend_tick_c2",  32'(tick),      0);
    step();
    check_eq("pend_tick_c3",  32'(tick),      1);
    check_eq("pend_ready_c3", 32'(cfg_ready), 0);
    check_eq("pend_div_c3",   32'(cur_div),   4);
    step();
    check_eq("apply_div",   32'(cur_div),   6);
    check_eq("apply_ready", 32'(cfg_ready), 1);
    run_check("div6", 6, 12);

    // Ratios 1 and 0 are rejected with one cfg_err pulse each
    cfg_valid = 1'b1;
    cfg_div   = 16'd1;
    step();
    check_eq("err1_pulse", 32'(cfg_err),   1);
    check_eq("err1_ready", 32'(cfg_ready), 1);
    check_eq("err1_div",   32'(cur_div),   6);
    cfg_div = 16'd0;
    step();
    cfg_valid = 1'b0;
    check_eq("err0_pulse", 32'(cfg_err),   1);
    check_eq("err0_ready", 32'(cfg_ready), 1);
    step();
    check_eq("err_clear",  32'(cfg_err),   0);
    check_eq("err_div",    32'(cur_div),   6);
    check_eq("err_ready",  32'(cfg_ready), 1);

    // Stop at count 3 of 6: tick at count 5, then idle
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("stop6_run_c4",  32'(running), 1);
    check_eq("stop6_tick_c4", 32'(tick),    0);
    step();
    check_eq("stop6_tick_c5", 32'(tick),    1);
    step();
    check_eq("stop6_idle_run",   32'(running), 0);
    check_eq("stop6_idle_tick",  32'(tick),    0);
    check_eq("stop6_idle_phase", 32'(phase),   0);

    // Start and stop together in IDLE are ignored
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check_eq("both_idle_run", 32'(running), 0);

    // Ratio written in IDLE applies on the next cycle
    cfg_valid = 1'b1;
    cfg_div   = 16'd5;
    step();
    cfg_valid = 1'b0;
    check_eq("idle_cfg_div",   32'(cur_div),   5);
    check_eq("idle_cfg_ready", 32'(cfg_ready), 1);

    // DIV=5: phase high for 2 of 5 cycles, ending with the tick
    start = 1'b1;
    step();
    start = 1'b0;
    run_check("div5", 5, 5);

    // Stop one cycle after a tick: one more tick 5 cycles after the last
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int c = 1; c < 5; c++) begin
      check_eq($sformatf("stop5_tick%0d", c),  32'(tick),    32'(c == 4));
      check_eq($sformatf("stop5_phase%0d", c), 32'(phase),   32'(c >= 3));
      check_eq($sformatf("stop5_run%0d", c),   32'(running), 1);
      step();
    end
    check_eq("stop5_idle_run",   32'(running), 0);
    check_eq("stop5_idle_phase", 32'(phase),   0);
    check_eq("stop5_idle_tick",  32'(tick),    0);
    step();
    check_eq("stop5_idle2_tick", 32'(tick),    0);

    // Start during STOPPING cancels the stop: no gap in ticks
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("cancel_run_c3", 32'(running), 1);
    step();
    check_eq("cancel_tick_c4", 32'(tick), 1);
    step();
    run_check("cancel", 5, 10);

    // Asynchronous reset mid-period with a ratio pending
    cfg_valid = 1'b1;
    cfg_div   = 16'd9;
    step();
    cfg_valid = 1'b0;
    check_eq("arst_pend_ready", 32'(cfg_ready), 0);
    step();
    step();
    check_eq("arst_pre_phase", 32'(phase), 1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals("arst");
    @(posedge clk_in);
    #2 reset_n = 1'b1;
    step();
    check_reset_vals("arst_rel");
    step();
    check_eq("arst_rel_div2", 32'(cur_div), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running simulation expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clk_en_ctrl.md
# clk_en_ctrl

Controller that sequences a programmable clock-enable divider for the matrix-multiply and VGA datapaths. It runs on the single fabric clock and drives a one-cycle `tick` enable every `cur_div` cycles, plus a `phase` square wave, instead of a derived clock. The divide ratio can be changed at runtime through a valid/ready config port; changes take effect only on a period boundary. Start and stop are graceful: the output never emits a runt period.

## Interface
- `DIV_W`, 16: width of divide-ratio fields.
- `DEFAULT_DIV`, 4: ratio loaded at reset; must be ≥ 2.
- `clk_in`  in  1: single system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cfg_valid`  in  1: new ratio offered.
- `cfg_ready`  out  1: holding register free; transfer when `cfg_valid && cfg_ready`.
- `cfg_div`  in  DIV_W: requested ratio.
- `cfg_err`  out  1: one-cycle pulse; the accepted ratio was < 2 and was discarded.
- `start`  in  1: begin generating ticks.
- `stop`  in  1: stop at the end of the current period.
- `tick`  out  1: one-cycle enable, once per period.
- `phase`  out  1: high for the last floor(`cur_div`/2) cycles of each period.
- `running`  out  1: high in RUN or STOPPING.
- `cur_div`  out  DIV_W: ratio currently in force.

## Operation
- Reset values: IDLE, counter 0, `cur_div`=`DEFAULT_DIV`, pending empty, `cfg_ready`=1, `cfg_err`=0, `tick`=0, `phase`=0, `running`=0.
- FSM states:
  - IDLE: start → RUN.
  - RUN: stop → STOPPING.
  - STOPPING: start → RUN, which cancels the stop. At the boundary → IDLE.
- Simultaneous start and stop:
  - In IDLE, both are ignored.
  - In RUN, stop wins.
  - In STOPPING, start wins.
- Period counter:
  - Counts 0..`cur_div`−1 and wraps.
  - Boundary is the cycle with counter = `cur_div`−1. `tick`=1 in exactly that cycle.
  - `phase`=1 when counter ≥ `cur_div` − floor(`cur_div`/2).
- Config handshake:
  - Accepted ratio < 2: pulse `cfg_err` and discard the ratio. The holding register stays empty.
  - In IDLE: a valid ratio loads `cur_div` on the next cycle; `cfg_ready` stays 1.
  - In RUN or STOPPING: a valid ratio goes to the one-entry pending register, and `cfg_ready` drops.
  - At the boundary: pending is copied to `cur_div`, the counter restarts at 0, and `cfg_ready` returns to 1 on the next cycle.
- Offering config at the boundary cycle itself: accepted into pending, applied at the next boundary.
- Entering IDLE: counter cleared, `phase`=0. A pending ratio is applied on that same transition.
- `reset_n` low mid-period: all state returns to reset values immediately. The pending ratio is lost.

## Timing
- `start` sampled high in IDLE at cycle T:
  - `running`=1 from T+1, with counter 0 at T+1.
  - First `tick` at T+`cur_div`, then every `cur_div` cycles.
- `stop` sampled in RUN at cycle S: the last `tick` is the first boundary ≥ S. `running`=0 the cycle after that tick.
- Config accepted while running: new spacing starts with the period that follows the next boundary. No period mixes two ratios.
- All outputs are registered. `tick` and `phase` are glitch-free with respect to `clk_in`.

## Structure
- Shared package `clk_ctrl_pkg`:
  - `state_t` enum (IDLE, RUN, STOPPING).
  - `MIN_DIV`=2.
- One natural sub-module, `period_counter`:
  - Inputs: `cur_div`, clear, enable.
  - Outputs: `boundary` and `phase`.
- The FSM and config holding register stay in `clk_en_ctrl`.

## Test plan
- Reset, then `start` with DIV=4: `tick` at T+4, T+8, T+12. `phase` pattern is 0,0,1,1 per period.
- Running at DIV=4, write `cfg_div`=6 mid-period:
  - `cfg_ready`=0 until the boundary.
  - Remaining period keeps 4-cycle spacing; the next spacing is 6.
  - `cur_div`=6 after the boundary.
- Write `cfg_div`=1 and `cfg_div`=0: `cfg_err` pulses once for each. `cur_div` is unchanged and `cfg_ready` stays 1.
- DIV=5, `stop` one cycle after a tick:
  - Exactly one more tick, 5 cycles later, then `running`=0 and `phase`=0.
  - `start` re-asserted during STOPPING: ticks continue with no gap.
- Odd DIV=5: `phase` high for exactly 2 of 5 cycles, ending at the tick cycle.
- `reset_n` pulsed low mid-period with a ratio pending: outputs return to reset values asynchronously. `cur_div`=4 and `cfg_ready`=1 after release.
